// File: rtl/hash_msg_feeder.sv
// Byte-stream front end for the 32-bit hash core: packs bytes into 4-byte blocks,
// appends 0x80 / zero fill / length byte and chains the core block by block.
module hash_msg_feeder #(
    parameter int CORE_LAT = 30,
    parameter int LEN_W    = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_data,
    input  logic        in_last,
    input  logic [31:0] iv_in,
    output logic        core_start,
    output logic [31:0] core_m,
    output logic [31:0] core_iv,
    input  logic [31:0] core_d,
    output logic [31:0] digest,
    output logic        digest_valid,
    input  logic        digest_ready
);

    localparam int CNT_W = (CORE_LAT > 2) ? $clog2(CORE_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_PAD,
        S_START,
        S_WAIT,
        S_CHAIN,
        S_OUT
    } state_t;

    state_t             state_q, state_d;
    logic [1:0]         idx_q, idx_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [7:0]         msg_buf_q [4];
    logic [7:0]         msg_buf_d [4];
    logic [31:0]        iv_reg_q, iv_reg_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               core_start_q, core_start_d;
    logic [31:0]        digest_q, digest_d;
    logic               digest_valid_q, digest_valid_d;
    logic               final_flag_q, final_flag_d;
    logic               pad_pending_q, pad_pending_d;
    logic               extra_mark_q, extra_mark_d;
    logic [7:0]         len_byte;

    assign len_byte     = 8'(len_q);
    assign in_ready     = (state_q == S_FILL);
    assign core_start   = core_start_q;
    assign core_iv      = iv_reg_q;
    assign digest       = digest_q;
    assign digest_valid = digest_valid_q;

    // byte 0 of the block sits in the most significant lane of core_m
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        assign core_m[31-8*gi -: 8] = msg_buf_q[gi];

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                msg_buf_q[gi] <= '0;
            end else begin
                msg_buf_q[gi] <= msg_buf_d[gi];
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        idx_d          = idx_q;
        len_d          = len_q;
        msg_buf_d      = msg_buf_q;
        iv_reg_d       = iv_reg_q;
        cnt_d          = cnt_q;
        digest_d       = digest_q;
        digest_valid_d = digest_valid_q;
        final_flag_d   = final_flag_q;
        pad_pending_d  = pad_pending_q;
        extra_mark_d   = extra_mark_q;

        case (state_q)
            S_FILL: begin
                if (in_valid) begin
                    msg_buf_d[idx_q] = in_data;
                    len_d            = len_q + LEN_W'(1);
                    if (len_q == '0) begin
                        iv_reg_d = iv_in;
                    end
                    // on the last byte idx is left at its position for padding
                    if (in_last) begin
                        state_d = S_PAD;
                    end else if (idx_q == 2'd3) begin
                        idx_d   = 2'd0;
                        state_d = S_START;
                    end else begin
                        idx_d = idx_q + 2'd1;
                    end
                end
            end

            S_PAD: begin
                case (idx_q)
                    2'd0: begin
                        msg_buf_d[1] = 8'h80;
                        msg_buf_d[2] = 8'h00;
                        msg_buf_d[3] = len_byte;
                        final_flag_d = 1'b1;
                    end
                    2'd1: begin
                        msg_buf_d[2] = 8'h80;
                        msg_buf_d[3] = len_byte;
                        final_flag_d = 1'b1;
                    end
                    2'd2: begin
                        msg_buf_d[3]  = 8'h80;
                        pad_pending_d = 1'b1;
                        extra_mark_d  = 1'b0;
                    end
                    default: begin
                        pad_pending_d = 1'b1;
                        extra_mark_d  = 1'b1;
                    end
                endcase
                state_d = S_START;
            end

            S_START: begin
                cnt_d   = CNT_LOAD;
                state_d = S_WAIT;
            end

            S_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = S_CHAIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            S_CHAIN: begin
                iv_reg_d = core_d;
                if (final_flag_q) begin
                    digest_d       = core_d;
                    digest_valid_d = 1'b1;
                    state_d        = S_OUT;
                end else if (pad_pending_q) begin
                    // overflow block: optional 0x80 marker, zeros, length byte
                    msg_buf_d[0]  = extra_mark_q ? 8'h80 : 8'h00;
                    msg_buf_d[1]  = 8'h00;
                    msg_buf_d[2]  = 8'h00;
                    msg_buf_d[3]  = len_byte;
                    pad_pending_d = 1'b0;
                    final_flag_d  = 1'b1;
                    state_d       = S_START;
                end else begin
                    idx_d   = 2'd0;
                    state_d = S_FILL;
                end
            end

            S_OUT: begin
                if (digest_ready) begin
                    digest_valid_d = 1'b0;
                    len_d          = '0;
                    idx_d          = 2'd0;
                    final_flag_d   = 1'b0;
                    state_d        = S_FILL;
                end
            end

            default: begin
                state_d = S_FILL;
            end
        endcase

        core_start_d = (state_d == S_START);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_FILL;
            idx_q          <= '0;
            len_q          <= '0;
            iv_reg_q       <= '0;
            cnt_q          <= '0;
            core_start_q   <= 1'b0;
            digest_q       <= '0;
            digest_valid_q <= 1'b0;
            final_flag_q   <= 1'b0;
            pad_pending_q  <= 1'b0;
            extra_mark_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            idx_q          <= idx_d;
            len_q          <= len_d;
            iv_reg_q       <= iv_reg_d;
            cnt_q          <= cnt_d;
            core_start_q   <= core_start_d;
            digest_q       <= digest_d;
            digest_valid_q <= digest_valid_d;
            final_flag_q   <= final_flag_d;
            pad_pending_q  <= pad_pending_d;
            extra_mark_q   <= extra_mark_d;
        end
    end

endmodule

// File: tb/tb_hash_msg_feeder.sv
// Randomized bench for hash_msg_feeder: a latency-accurate hash core stand-in plus
// a padding/chaining reference model computed directly from byte queues.
module tb_hash_msg_feeder;

    localparam int CORE_LAT = 30;
    localparam int BOUND    = 4 * CORE_LAT + 50;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        in_last = 1'b0;
    logic [31:0] iv_in = '0;
    logic        core_start;
    logic [31:0] core_m;
    logic [31:0] core_iv;
    logic [31:0] core_d = '0;
    logic [31:0] digest;
    logic        digest_valid;
    logic        digest_ready = 1'b0;

    always #5 clk = ~clk;

    hash_msg_feeder #(
        .CORE_LAT (CORE_LAT),
        .LEN_W    (8)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .in_last      (in_last),
        .iv_in        (iv_in),
        .core_start   (core_start),
        .core_m       (core_m),
        .core_iv      (core_iv),
        .core_d       (core_d),
        .digest       (digest),
        .digest_valid (digest_valid),
        .digest_ready (digest_ready)
    );

    int checks_cnt = 0;
    int errors_cnt = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks_cnt++;
        if (obs !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // toy compression function standing in for the real core
    function automatic logic [31:0] core_f(input logic [31:0] m, input logic [31:0] iv);
        logic [31:0] x;
        x = m ^ {iv[24:0], iv[31:25]};
        x = x * 32'h9E3779B1 + iv;
        return x ^ (x >> 15);
    endfunction

    // core stand-in: junk on core_d until exactly CORE_LAT cycles after the start cycle
    logic [31:0] core_res = '0;
    int          core_cnt = 0;
    logic [31:0] obs_m_q[$];
    logic [31:0] obs_iv_q[$];

    always @(negedge clk) begin
        if (!rst_n) begin
            core_cnt <= 0;
        end else if (core_start) begin
            obs_m_q.push_back(core_m);
            obs_iv_q.push_back(core_iv);
            core_res <= core_f(core_m, core_iv);
            core_cnt <= CORE_LAT + 1;
            core_d   <= $urandom;
        end else if (core_cnt > 0) begin
            core_cnt <= core_cnt - 1;
            if (core_cnt == 1) begin
                core_d <= core_res;
            end
        end
    end

    function automatic logic [31:0] obs_m_at(input int k);
        return (k < obs_m_q.size()) ? obs_m_q[k] : 32'hxxxxxxxx;
    endfunction

    function automatic logic [31:0] obs_iv_at(input int k);
        return (k < obs_iv_q.size()) ? obs_iv_q[k] : 32'hxxxxxxxx;
    endfunction

    // called at a negedge; returns at the negedge after the accepting edge
    task automatic send_byte(input logic [7:0] d, input bit last, input logic [31:0] iv,
                             output bit rdy_after);
        int n;
        n        = 0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        iv_in    = iv;
        while (!in_ready && n < BOUND) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        rdy_after = in_ready;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = 8'($urandom);
        iv_in     = $urandom;
    endtask

    logic [7:0] msg_q[$];

    // hold < 0: digest_ready already high when digest_valid rises
    task automatic run_msg(input string tag, input logic [31:0] iv, input int hold);
        logic [7:0]  pad[$];
        logic [31:0] exp_m[$];
        logic [31:0] exp_iv[$];
        logic [31:0] h;
        logic [31:0] blk;
        int          len;
        int          lat;
        int          exp_lat;
        bit          rdy;
        bit          stable;

        len = msg_q.size();
        pad = msg_q;
        pad.push_back(8'h80);
        while (pad.size() % 4 != 3) pad.push_back(8'h00);
        pad.push_back(8'(len));
        h = iv;
        for (int b = 0; b < pad.size() / 4; b++) begin
            blk = {pad[4*b], pad[4*b+1], pad[4*b+2], pad[4*b+3]};
            exp_m.push_back(blk);
            exp_iv.push_back(h);
            h = core_f(blk, h);
        end
        exp_lat = (len % 4 == 1 || len % 4 == 2) ? CORE_LAT + 3 : 2 * CORE_LAT + 5;

        obs_m_q.delete();
        obs_iv_q.delete();
        for (int i = 0; i < len; i++) begin
            repeat ($urandom_range(0, 2)) @(negedge clk);
            send_byte(msg_q[i], i == len - 1, (i == 0) ? iv : $urandom, rdy);
            check($sformatf("%s_rdy%0d", tag, i), 32'(rdy),
                  (i == len - 1 || i % 4 == 3) ? 32'd0 : 32'd1);
        end
        if (hold < 0) digest_ready = 1'b1;

        lat = 0;
        while (!digest_valid && lat < BOUND) begin
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(exp_lat));
        check({tag, "_digest"}, digest, h);
        check({tag, "_nblk"}, 32'(obs_m_q.size()), 32'(exp_m.size()));
        for (int b = 0; b < exp_m.size(); b++) begin
            check($sformatf("%s_m%0d", tag, b), obs_m_at(b), exp_m[b]);
            check($sformatf("%s_iv%0d", tag, b), obs_iv_at(b), exp_iv[b]);
        end

        stable = 1'b1;
        if (hold > 0) begin
            in_valid = 1'b1;
            in_data  = 8'($urandom);
            for (int k = 0; k < hold; k++) begin
                @(negedge clk);
                if (!digest_valid || digest !== h || in_ready) stable = 1'b0;
            end
        end
        check({tag, "_hold"}, 32'(stable), 32'd1);
        digest_ready = 1'b1;
        @(negedge clk);
        digest_ready = 1'b0;
        in_valid     = 1'b0;
        check({tag, "_dv_clr"}, 32'(digest_valid), 32'd0);
        check({tag, "_rdy_back"}, 32'(in_ready), 32'd1);
        $display("msg %s len=%0d blocks=%0d lat=%0d digest=%h hold=%0d",
                 tag, len, obs_m_q.size(), lat, digest, hold);
    endtask

    initial begin
        bit          rdy;
        logic [31:0] iv2;

        repeat (3) @(negedge clk);
        check("rst_core_start", 32'(core_start), 32'd0);
        check("rst_core_m", core_m, 32'd0);
        check("rst_core_iv", core_iv, 32'd0);
        check("rst_digest", digest, 32'd0);
        check("rst_digest_valid", 32'(digest_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        @(negedge clk);

        msg_q = {8'hAA};
        run_msg("t1", 32'h01234567, 3);
        check("t1_m0_const", obs_m_at(0), 32'hAA800001);
        check("t1_iv0_const", obs_iv_at(0), 32'h01234567);

        msg_q = {8'h11, 8'h22, 8'h33};
        run_msg("t2", $urandom, 0);
        check("t2_m0_const", obs_m_at(0), 32'h11223380);
        check("t2_m1_const", obs_m_at(1), 32'h00000003);

        msg_q = {8'h11, 8'h22, 8'h33, 8'h44};
        run_msg("t3", $urandom, 1);
        check("t3_m0_const", obs_m_at(0), 32'h11223344);
        check("t3_m1_const", obs_m_at(1), 32'h80000004);

        msg_q = {8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06};
        run_msg("t4", $urandom, 2);
        check("t4_m0_const", obs_m_at(0), 32'h01020304);
        check("t4_m1_const", obs_m_at(1), 32'h05068006);

        msg_q = {8'hC3};
        run_msg("t5_bp", $urandom, 10);

        msg_q = {8'h7E, 8'h7F};
        run_msg("t5_same", $urandom, -1);

        for (int r = 0; r < 16; r++) begin
            msg_q.delete();
            repeat ($urandom_range(1, 13)) msg_q.push_back(8'($urandom));
            run_msg($sformatf("rnd%0d", r), $urandom, $urandom_range(0, 4));
        end

        // reset while block 2 of an unfinished message is in the core
        obs_m_q.delete();
        obs_iv_q.delete();
        iv2 = $urandom;
        for (int i = 0; i < 8; i++) send_byte(8'(i + 1), 1'b0, iv2, rdy);
        repeat (5) @(negedge clk);
        check("t6_pre_starts", 32'(obs_m_q.size()), 32'd2);
        rst_n = 1'b0;
        #1;
        check("t6_core_start", 32'(core_start), 32'd0);
        check("t6_core_m", core_m, 32'd0);
        check("t6_core_iv", core_iv, 32'd0);
        check("t6_digest", digest, 32'd0);
        check("t6_digest_valid", 32'(digest_valid), 32'd0);
        check("t6_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        iv2   = $urandom;
        msg_q = {8'h5A};
        run_msg("t6", iv2, 1);
        check("t6_m0_const", obs_m_at(0), 32'h5A800001);
        check("t6_iv0_const", obs_iv_at(0), iv2);

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
